alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_exec_unit.sv | 182 ++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// ALU execute unit: single-cycle ALU ops plus a multi-cycle
// shift-add multiply-accumulate (MULA), with valid/ready flow control.
// Ports:
//   CLK, Reset                       clock, sync active-high reset
//   InValid/InReady                  request handshake
//   ALUCtrl, BusA, BusB, Shamt       operation and operands
//   AccClear                         clear MULA accumulator (IDLE only)
//   OutValid/OutReady                result handshake
//   BusW, Zero, Overflow             registered result and flags
module alu_exec_unit (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        InValid,
  output logic        InReady,
  input  logic [3:0]  ALUCtrl,
  input  logic [31:0] BusA,
  input  logic [31:0] BusB,
  input  logic [4:0]  Shamt,
  input  logic        AccClear,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] BusW,
  output logic        Zero,
  output logic        Overflow
);

  localparam logic [3:0] OP_AND  = 4'h0;
  localparam logic [3:0] OP_OR   = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SLL  = 4'h3;
  localparam logic [3:0] OP_SRL  = 4'h4;
  localparam logic [3:0] OP_MULA = 4'h5;
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_SLT  = 4'h7;
  localparam logic [3:0] OP_ADDU = 4'h8;
  localparam logic [3:0] OP_SUBU = 4'h9;
  localparam logic [3:0] OP_XOR  = 4'hA;
  localparam logic [3:0] OP_SLTU = 4'hB;
  localparam logic [3:0] OP_NOR  = 4'hC;
  localparam logic [3:0] OP_SRA  = 4'hD;
  localparam logic [3:0] OP_LUI  = 4'hE;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] prod_q, prod_d;
  logic        ov_q, ov_d;
  logic [31:0] busw_q, busw_d;
  logic        zero_q, zero_d;
  logic        ovf_q, ovf_d;

  logic [31:0] sum, diff, res, acc_sum;
  logic        res_ovf, accept;

  assign sum     = BusA + BusB;
  assign diff    = BusA - BusB;
  assign acc_sum = acc_q + prod_q;

  always_comb begin
    res     = 32'h0;
    res_ovf = 1'b0;
    unique case (ALUCtrl)
      OP_AND:  res = BusA & BusB;
      OP_OR:   res = BusA | BusB;
      OP_ADD: begin
        res     = sum;
        res_ovf = (BusA[31] == BusB[31]) && (sum[31] != BusA[31]);
      end
      OP_SLL:  res = BusB << Shamt;
      OP_SRL:  res = BusB >> Shamt;
      OP_SUB: begin
        res     = diff;
        res_ovf = (BusA[31] != BusB[31]) && (diff[31] != BusA[31]);
      end
      OP_SLT:  res = {31'h0, $signed(BusA) < $signed(BusB)};
      OP_ADDU: res = sum;
      OP_SUBU: res = diff;
      OP_XOR:  res = BusA ^ BusB;
      OP_SLTU: res = {31'h0, BusA < BusB};
      OP_NOR:  res = ~(BusA | BusB);
      OP_SRA:  res = $unsigned($signed(BusB) >>> Shamt);
      OP_LUI:  res = {BusB[15:0], 16'h0000};
      default: res = 32'h0;
    endcase
  end

  assign InReady = (state_q == S_IDLE) && (!ov_q || OutReady);
  assign accept  = InValid && InReady;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    ov_d     = ov_q;
    busw_d   = busw_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    if (ov_q && OutReady) ov_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (AccClear) acc_d = 32'h0;
        if (accept) begin
          if (ALUCtrl == OP_MULA) begin
            state_d  = S_MUL;
            cnt_d    = 6'd0;
            mcand_d  = BusA;
            mplier_d = BusB;
            prod_d   = 32'h0;
          end else begin
            ov_d   = 1'b1;
            busw_d = res;
            zero_d = (res == 32'h0);
            ovf_d  = res_ovf;
          end
        end
      end
      S_MUL: begin
        // 32 shift-add steps, then one cycle to hand off to DONE.
        if (cnt_q == 6'd32) begin
          state_d = S_DONE;
        end else begin
          if (mplier_q[0]) prod_d = prod_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 6'd1;
        end
      end
      S_DONE: begin
        acc_d   = acc_sum;
        ov_d    = 1'b1;
        busw_d  = acc_sum;
        zero_d  = (acc_sum == 32'h0);
        ovf_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      acc_q    <= 32'h0;
      cnt_q    <= 6'd0;
      mcand_q  <= 32'h0;
      mplier_q <= 32'h0;
      prod_q   <= 32'h0;
      ov_q     <= 1'b0;
      busw_q   <= 32'h0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      ov_q     <= ov_d;
      busw_q   <= busw_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign OutValid = ov_q;
  assign BusW     = busw_q;
  assign Zero     = zero_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed testbench for alu_exec_unit.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_alu_exec_unit;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [3:0]  ALUCtrl = 4'h0;
  logic [31:0] BusA = 32'h0;
  logic [31:0] BusB = 32'h0;
  logic [4:0]  Shamt = 5'd0;
  logic        AccClear = 1'b0;
  logic        OutValid;
  logic        OutReady = 1'b1;
  logic [31:0] BusW;
  logic        Zero;
  logic        Overflow;

  int asserts = 0;
  int fails = 0;

  alu_exec_unit dut (
    .CLK(CLK), .Reset(Reset),
    .InValid(InValid), .InReady(InReady),
    .ALUCtrl(ALUCtrl), .BusA(BusA), .BusB(BusB),
    .Shamt(Shamt), .AccClear(AccClear),
    .OutValid(OutValid), .OutReady(OutReady),
    .BusW(BusW), .Zero(Zero), .Overflow(Overflow)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  s;
    logic [31:0] w;
    logic        z;
    logic        v;
  } vec_t;

  localparam int NSEQ = 14;
  localparam vec_t SEQ [NSEQ] = '{
    '{4'h6, 32'h5,        32'h5,        5'd0,  32'h0,        1'b1, 1'b0},
    '{4'h7, 32'hFFFFFFFF, 32'h1,        5'd0,  32'h1,        1'b0, 1'b0},
    '{4'hB, 32'hFFFFFFFF, 32'h1,        5'd0,  32'h0,        1'b1, 1'b0},
    '{4'hD, 32'h0,        32'h80000000, 5'd4,  32'hF8000000, 1'b0, 1'b0},
    '{4'hE, 32'h0,        32'h00001234, 5'd0,  32'h12340000, 1'b0, 1'b0},
    '{4'h0, 32'hF0F0FF00, 32'h0FF0F0F0, 5'd0,  32'h00F0F000, 1'b0, 1'b0},
    '{4'h1, 32'hF0F0FF00, 32'h0FF0F0F0, 5'd0,  32'hFFF0FFF0, 1'b0, 1'b0},
    '{4'hA, 32'hF0F0FF00, 32'h0FF0F0F0, 5'd0,  32'hFF000FF0, 1'b0, 1'b0},
    '{4'hC, 32'h0,        32'h0,        5'd0,  32'hFFFFFFFF, 1'b0, 1'b0},
    '{4'h3, 32'h0,        32'h1,        5'd31, 32'h80000000, 1'b0, 1'b0},
    '{4'h4, 32'h0,        32'h80000000, 5'd31, 32'h1,        1'b0, 1'b0},
    '{4'h6, 32'h80000000, 32'h1,        5'd0,  32'h7FFFFFFF, 1'b0, 1'b1},
    '{4'h9, 32'h80000000, 32'h1,        5'd0,  32'h7FFFFFFF, 1'b0, 1'b0},
    '{4'hF, 32'h12345678, 32'h9ABCDEF0, 5'd3,  32'h0,        1'b1, 1'b0}
  };

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present a request for one cycle; it is accepted on the next edge.
  task automatic issue(input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] s);
    ALUCtrl = c;
    BusA    = a;
    BusB    = b;
    Shamt   = s;
    InValid = 1'b1;
    tick();
    InValid = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    tick();
    asserts++;
    if ({OutValid, BusW, Zero, Overflow} !== {1'b0, 32'h0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL reset_out: got v=%b w=%h z=%b o=%b want v=0 w=0 z=1 o=0",
               OutValid, BusW, Zero, Overflow);
    end
    Reset = 1'b0;
    #1;
    asserts++;
    if (InReady !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got %b want 1", InReady);
    end
  endtask

  task automatic test_add_overflow();
    OutReady = 1'b1;
    issue(4'h2, 32'h7FFFFFFF, 32'h1, 5'd0);
    asserts++;
    if ({OutValid, BusW, Zero, Overflow} !== {1'b1, 32'h80000000, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL add_ovf: got v=%b w=%h z=%b o=%b want v=1 w=80000000 z=0 o=1",
               OutValid, BusW, Zero, Overflow);
    end
    issue(4'h8, 32'h7FFFFFFF, 32'h1, 5'd0);
    asserts++;
    if ({OutValid, BusW, Zero, Overflow} !== {1'b1, 32'h80000000, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL addu_noovf: got v=%b w=%h z=%b o=%b want v=1 w=80000000 z=0 o=0",
               OutValid, BusW, Zero, Overflow);
    end
    tick();
    asserts++;
    if (OutValid !== 1'b0) begin
      fails++;
      $display("FAIL add_drain: OutValid got %b want 0", OutValid);
    end
  endtask

  // Issued back-to-back: one result per cycle with OutReady held high.
  task automatic test_back_to_back();
    OutReady = 1'b1;
    for (int i = 0; i < NSEQ; i++) begin
      issue(SEQ[i].c, SEQ[i].a, SEQ[i].b, SEQ[i].s);
      asserts++;
      if ({OutValid, BusW, Zero, Overflow} !==
          {1'b1, SEQ[i].w, SEQ[i].z, SEQ[i].v}) begin
        fails++;
        $display("FAIL seq_op%0d code=%h: got v=%b w=%h z=%b o=%b want v=1 w=%h z=%b o=%b",
                 i, SEQ[i].c, OutValid, BusW, Zero, Overflow,
                 SEQ[i].w, SEQ[i].z, SEQ[i].v);
      end
    end
    tick();
  endtask

  task automatic run_mula(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] want, input string tag);
    issue(4'h5, a, b, 5'd0);
    asserts++;
    if ({OutValid, InReady} !== 2'b00) begin
      fails++;
      $display("FAIL %s_accept: got v=%b r=%b want v=0 r=0", tag, OutValid, InReady);
    end
    for (int k = 1; k <= 34; k++) begin
      tick();
      if (k < 34) begin
        asserts++;
        if ({OutValid, InReady} !== 2'b00) begin
          fails++;
          $display("FAIL %s_busy cyc%0d: got v=%b r=%b want v=0 r=0",
                   tag, k, OutValid, InReady);
        end
      end else begin
        asserts++;
        if ({OutValid, BusW, Overflow} !== {1'b1, want, 1'b0}) begin
          fails++;
          $display("FAIL %s_result: got v=%b w=%h o=%b want v=1 w=%h o=0",
                   tag, OutValid, BusW, Overflow, want);
        end
      end
    end
  endtask

  task automatic test_mula();
    OutReady = 1'b1;
    AccClear = 1'b1;
    tick();
    AccClear = 1'b0;
    run_mula(32'd3, 32'd4, 32'h0000000C, "mula1");
    run_mula(32'd5, 32'd6, 32'h0000002A, "mula2");
    tick();
  endtask

  task automatic test_backpressure();
    OutReady = 1'b0;
    issue(4'h2, 32'd1, 32'd2, 5'd0);
    ALUCtrl = 4'h6;
    BusA    = 32'd9;
    BusB    = 32'd1;
    InValid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      asserts++;
      if ({OutValid, BusW, InReady} !== {1'b1, 32'h3, 1'b0}) begin
        fails++;
        $display("FAIL bp_hold cyc%0d: got v=%b w=%h r=%b want v=1 w=3 r=0",
                 k, OutValid, BusW, InReady);
      end
      tick();
    end
    OutReady = 1'b1;
    #1;
    asserts++;
    if (InReady !== 1'b1) begin
      fails++;
      $display("FAIL bp_release_ready: got %b want 1", InReady);
    end
    tick();
    InValid = 1'b0;
    asserts++;
    if ({OutValid, BusW} !== {1'b1, 32'h8}) begin
      fails++;
      $display("FAIL bp_next_op: got v=%b w=%h want v=1 w=8", OutValid, BusW);
    end
    tick();
    asserts++;
    if (OutValid !== 1'b0) begin
      fails++;
      $display("FAIL bp_drain: OutValid got %b want 0", OutValid);
    end
  endtask

  task automatic test_reset_mid_mul();
    OutReady = 1'b1;
    issue(4'h5, 32'd7, 32'd7, 5'd0);
    for (int k = 1; k < 10; k++) tick();
    Reset = 1'b1;
    tick();
    asserts++;
    if ({OutValid, BusW, Zero} !== {1'b0, 32'h0, 1'b1}) begin
      fails++;
      $display("FAIL rst_mid_out: got v=%b w=%h z=%b want v=0 w=0 z=1",
               OutValid, BusW, Zero);
    end
    Reset = 1'b0;
    #1;
    asserts++;
    if (InReady !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_ready: got %b want 1", InReady);
    end
    run_mula(32'd2, 32'd2, 32'h00000004, "mula_post_rst");
    tick();
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_back_to_back();
    test_mula();
    test_backpressure();
    test_reset_mid_mul();
    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts, fails);
    $finish;
  end

endmodule
